sd_sector_bridge: RTL

Memory-mapped bridge between the CPU data bus and the SPI-mode sd_controller. It has two ping-pong sector buffers. The SD side fills the back buffer while the CPU reads the front buffer, and a completed fill swaps the two. It replaces the single-buffer, fixed-512-byte SD cache logic in the board top, and adds a busy/error status and a short-sector abort.

---
 rtl/sd_sector_bridge_if.sv | 32 +++
 rtl/sd_sector_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_bridge_if.sv
// sd_sector_bridge_if: CPU bus window plus sd_controller handshake for sd_sector_bridge.
// The slave modport is the bridge; the master modport is the CPU/SD-controller side.
interface sd_sector_bridge_if #(
    parameter int ADDR_W    = 64,
    parameter int SD_ADDR_W = 32
);
    logic                 bus_sel;
    logic [ADDR_W-1:0]    bus_addr;
    logic                 bus_re;
    logic                 bus_we;
    logic [63:0]          bus_wdata;
    logic [63:0]          bus_rdata;
    logic                 bus_rdone;
    logic                 sd_rd;
    logic [SD_ADDR_W-1:0] sd_addr;
    logic [7:0]           sd_dout;
    logic                 sd_byte_available;
    logic                 sd_ready;
    logic                 irq;

    modport slave (
        input  bus_sel, bus_addr, bus_re, bus_we, bus_wdata,
        input  sd_dout, sd_byte_available, sd_ready,
        output bus_rdata, bus_rdone, sd_rd, sd_addr, irq
    );

    modport master (
        output bus_sel, bus_addr, bus_re, bus_we, bus_wdata,
        output sd_dout, sd_byte_available, sd_ready,
        input  bus_rdata, bus_rdone, sd_rd, sd_addr, irq
    );
endinterface

// File: rtl/sd_sector_bridge.sv
// sd_sector_bridge: memory-mapped ping-pong sector buffer in front of sd_controller.
// The SD side fills the back buffer while the CPU reads the front one; a full sector swaps them.
// Optional feature macro: SD_SECTOR_PREFETCH_EN (auto-advance ADDR and chain the next sector read).
module sd_sector_bridge #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 64,
    parameter int SD_ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    sd_sector_bridge_if.slave bus
);
    localparam int LW = $clog2(SECTOR_BYTES);
    localparam int CW = LW + 1;
    localparam logic [ADDR_W-1:0] OFF_ADDR   = ADDR_W'(SECTOR_BYTES);
    localparam logic [ADDR_W-1:0] OFF_CMD    = ADDR_W'(SECTOR_BYTES) + ADDR_W'(32'd8);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(SECTOR_BYTES) + ADDR_W'(32'd16);
    localparam logic [ADDR_W-1:0] OFF_COUNT  = ADDR_W'(SECTOR_BYTES) + ADDR_W'(32'd24);
    localparam logic [CW-1:0]     FULL_CNT   = CW'(SECTOR_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_FILL     = 3'd3,
        ST_SWAP     = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 front_q, front_d;
    logic [SD_ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 avail_q, avail_d;
    logic                 busy_q, busy_d;
    logic                 err_short_q, err_short_d;
    logic                 err_busy_q, err_busy_d;
    logic                 irq_en_q, irq_en_d;
    logic                 pf_stop_q, pf_stop_d;
    logic                 bav_q, bav_d;
    logic [63:0]          rdata_q, rdata_d;
    logic                 rdone_q, rdone_d;
    logic                 sd_rd_q, sd_rd_d;
    logic [SD_ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic                 irq_q, irq_d;

    // Two sector buffers; index MSB selects the buffer, front_q marks the CPU-visible one.
    logic [7:0] buf_mem [2*SECTOR_BYTES];

    logic          cmd_wr_s, addr_wr_s, start_req_s, start_ok_s;
    logic          issue_fire_s, capture_s, full_s, short_s, swap_s, chain_s;
    logic [CW-1:0] count_inc_s;
    logic [63:0]   rd_val_s;
    logic          unused_ok_s;

    assign cmd_wr_s    = bus.bus_sel & bus.bus_we & (bus.bus_addr == OFF_CMD);
    assign addr_wr_s   = bus.bus_sel & bus.bus_we & (bus.bus_addr == OFF_ADDR);
    assign start_req_s = cmd_wr_s & bus.bus_wdata[0];
    assign start_ok_s  = start_req_s & ~busy_q;
    assign unused_ok_s = ^bus.bus_wdata;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     state_d = start_ok_s ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:    state_d = bus.sd_ready ? ST_WAIT_ACK : ST_ISSUE;
            ST_WAIT_ACK: state_d = bus.sd_ready ? ST_WAIT_ACK : ST_FILL;
            ST_FILL:     state_d = full_s ? ST_SWAP : (short_s ? ST_IDLE : ST_FILL);
            ST_SWAP:     state_d = chain_s ? ST_ISSUE : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: read issue, one byte capture per strobe edge, end-of-fill events.
    always_comb begin
        issue_fire_s = (state_q == ST_ISSUE) & bus.sd_ready;
        capture_s    = (state_q == ST_FILL) & bus.sd_byte_available & ~bav_q & (count_q < FULL_CNT);
        count_inc_s  = count_q + CW'(capture_s);
        full_s       = (state_q == ST_FILL) & (count_inc_s == FULL_CNT);
        short_s      = (state_q == ST_FILL) & ~full_s & bus.sd_ready;
        swap_s       = (state_q == ST_SWAP);
`ifdef SD_SECTOR_PREFETCH_EN
        chain_s      = swap_s & ~err_short_q & ~err_busy_q & ~pf_stop_q;
`else
        chain_s      = 1'b0;
`endif
    end

    // Read mux: front-buffer byte or register value for the current bus address.
    always_comb begin
        rd_val_s = 64'd0;
        if (bus.bus_addr < OFF_ADDR) begin
            rd_val_s = {56'd0, buf_mem[{front_q, bus.bus_addr[LW-1:0]}]};
        end else begin
            case (bus.bus_addr)
                OFF_ADDR:   rd_val_s = 64'(addr_q);
                OFF_STATUS: rd_val_s = {57'd0, pf_stop_q, irq_en_q, err_short_q, err_busy_q,
                                        busy_q, avail_q, bus.sd_ready};
                OFF_COUNT:  rd_val_s = 64'(count_q);
                default:    rd_val_s = 64'd0;
            endcase
        end
    end

    // Control/status next values; error sets come after clears so a same-cycle set wins.
    always_comb begin
        front_d     = front_q;
        addr_d      = addr_q;
        count_d     = count_q;
        avail_d     = avail_q;
        busy_d      = busy_q;
        err_short_d = err_short_q;
        err_busy_d  = err_busy_q;
        irq_en_d    = irq_en_q;
        pf_stop_d   = pf_stop_q;
        bav_d       = bus.sd_byte_available;
        rdone_d     = bus.bus_sel & bus.bus_re;
        rdata_d     = rdone_d ? rd_val_s : rdata_q;
        sd_rd_d     = issue_fire_s;
        sd_addr_d   = issue_fire_s ? addr_q : sd_addr_q;

        if (cmd_wr_s) begin
            irq_en_d = bus.bus_wdata[2];
            if (bus.bus_wdata[1]) begin
                err_short_d = 1'b0;
                err_busy_d  = 1'b0;
            end else begin
            end
`ifdef SD_SECTOR_PREFETCH_EN
            if (bus.bus_wdata[3]) begin
                pf_stop_d = 1'b1;
            end else begin
            end
`endif
        end else begin
        end

        if (start_req_s) begin
            if (busy_q) begin
                err_busy_d = 1'b1;
            end else begin
                busy_d  = 1'b1;
                avail_d = 1'b0;
                count_d = '0;
`ifdef SD_SECTOR_PREFETCH_EN
                pf_stop_d = bus.bus_wdata[3];
`endif
            end
        end else begin
        end

        if (capture_s) begin
            count_d = count_inc_s;
        end else begin
        end

        if (short_s) begin
            err_short_d = 1'b1;
            busy_d      = 1'b0;
        end else begin
        end

        if (swap_s) begin
            front_d = ~front_q;
            avail_d = 1'b1;
`ifdef SD_SECTOR_PREFETCH_EN
            addr_d  = addr_q + SD_ADDR_W'(1'b1);
            if (chain_s) begin
                count_d = '0;
                busy_d  = 1'b1;
            end else begin
                busy_d  = 1'b0;
            end
`else
            busy_d  = 1'b0;
`endif
        end else begin
        end

        // A CPU write to ADDR takes precedence over the hardware increment.
        if (addr_wr_s) begin
            addr_d = bus.bus_wdata[SD_ADDR_W-1:0];
        end else begin
        end

        irq_d = avail_d & irq_en_d;
    end

    // Control/status and bus-output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            front_q     <= 1'b0;
            addr_q      <= '0;
            count_q     <= '0;
            avail_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_busy_q  <= 1'b0;
            irq_en_q    <= 1'b0;
            pf_stop_q   <= 1'b0;
            bav_q       <= 1'b0;
            rdata_q     <= 64'd0;
            rdone_q     <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_addr_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            front_q     <= front_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            avail_q     <= avail_d;
            busy_q      <= busy_d;
            err_short_q <= err_short_d;
            err_busy_q  <= err_busy_d;
            irq_en_q    <= irq_en_d;
            pf_stop_q   <= pf_stop_d;
            bav_q       <= bav_d;
            rdata_q     <= rdata_d;
            rdone_q     <= rdone_d;
            sd_rd_q     <= sd_rd_d;
            sd_addr_q   <= sd_addr_d;
            irq_q       <= irq_d;
        end
    end

    // Back-buffer write port; RAM contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            buf_mem[{~front_q, count_q[LW-1:0]}] <= bus.sd_dout;
        end
    end

    assign bus.bus_rdata = rdata_q;
    assign bus.bus_rdone = rdone_q;
    assign bus.sd_rd     = sd_rd_q;
    assign bus.sd_addr   = sd_addr_q;
    assign bus.irq       = irq_q;
endmodule
